interval_meter: RTL and testbench

Measures the time between a start event and a stop event, in units of TICK_CYCLES clock cycles, and presents the result as a saturating two-digit BCD value for the dual seven-segment display path. It is the measuring counterpart of the fixed-delay pulse generator: that block turns a trigger into a pulse a known time later, and this block turns two events back into an elapsed-time reading. With the 1 kHz system clock and the default TICK_CYCLES = 100, it reads 0.0–9.9 s in 0.1 s steps.

---
 rtl/interval_meter_pkg.sv | 17 +
 rtl/bcd2_counter.sv | 50 +++++
 rtl/interval_meter.sv | 94 +++++++++
 tb/tb_interval_meter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/interval_meter_pkg.sv
// interval_meter_pkg: shared types and constants for the interval meter.
//   state_t     - measurement FSM states (IDLE, RUN, HOLD)
//   bcd_digit_t - one 4-bit BCD digit
//   BCD_MAX     - largest legal digit value
package interval_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit synchronous BCD incrementer that saturates at 99.
//   clk, rst - clock and synchronous active-high reset
//   clr_i    - clear both digits to 0 (wins over inc_i)
//   inc_i    - advance the count by one
//   tens_o   - tens digit, 0-9
//   ones_o   - ones digit, 0-9
//   sat_o    - increment requested while already at 99 (digits stay 99)
module bcd2_counter
    import interval_meter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    output bcd_digit_t tens_o,
    output bcd_digit_t ones_o,
    output logic       sat_o
);

    bcd_digit_t tens_q, tens_d;
    bcd_digit_t ones_q, ones_d;
    logic       at_max;
    logic       step;

    always_comb begin
        at_max = (tens_q == BCD_MAX) && (ones_q == BCD_MAX);
        sat_o  = inc_i && at_max;
        step   = inc_i && !at_max;
        ones_d = clr_i ? '0
               : step  ? ((ones_q == BCD_MAX) ? '0 : ones_q + 4'd1)
               : ones_q;
        tens_d = clr_i ? '0
               : (step && ones_q == BCD_MAX) ? tens_q + 4'd1
               : tens_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o = tens_q;
    assign ones_o = ones_q;

endmodule

// File: rtl/interval_meter.sv
// interval_meter: measures start-to-stop time in TICK_CYCLES units as a saturating 2-digit BCD value.
//   TICK_CYCLES        - clock cycles per count unit (>= 2)
//   clk, rst           - clock and synchronous active-high reset
//   start, stop        - event inputs; only rising edges are acted on
//   busy               - measurement in progress
//   done               - one-cycle pulse after entering HOLD
//   valid              - finished result on the digits
//   overflow           - result saturated at 99
//   bcd_tens, bcd_ones - result digits
module interval_meter
    import interval_meter_pkg::*;
#(
    parameter int TICK_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic       overflow,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);

    localparam int            PW   = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);

    state_t        state_q, state_d;
    logic          start_q, stop_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          start_edge, stop_edge;
    logic          tick, clr, sat;
    bcd_digit_t    tens, ones;

    assign start_edge = start && !start_q;
    assign stop_edge  = stop && !stop_q;
    assign tick       = (state_q == RUN) && (presc_q == PMAX);

    bcd2_counter u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .inc_i  (tick),
        .tens_o (tens),
        .ones_o (ones),
        .sat_o  (sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            presc_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            stop_q  <= stop;
            presc_q <= presc_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // In RUN the tick's increment lands in the same edge as a stop, so stop and saturation both just end the run.
    always_comb begin
        state_d = (state_q == RUN) ? ((sat || stop_edge) ? HOLD : RUN)
                                   : (start_edge ? RUN : state_q);
    end

    // Start from IDLE or HOLD begins a fresh measurement; start during RUN is ignored.
    always_comb begin
        clr     = (state_q != RUN) && start_edge;
        presc_d = (clr || tick)     ? '0
                : (state_q == RUN)  ? presc_q + 1'b1
                : presc_q;
        done_d  = (state_q == RUN) && (state_d == HOLD);
        ovf_d   = clr ? 1'b0 : (sat ? 1'b1 : ovf_q);
    end

    assign busy     = (state_q == RUN);
    assign valid    = (state_q == HOLD);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd_tens = tens;
    assign bcd_ones = ones;

endmodule

// File: tb/tb_interval_meter.sv
// tb_interval_meter: directed self-checking bench for interval_meter with TICK_CYCLES = 4.
module tb_interval_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy, done, valid, overflow;
    logic [3:0]  bcd_tens, bcd_ones;
    logic [11:0] obs, exp;
    int          tests = 0;
    int          fails = 0;

    interval_meter #(.TICK_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .overflow (overflow),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones)
    );

    always #5 clk = ~clk;

    // Packed view: {busy, done, valid, overflow, tens, ones}
    assign obs = {busy, done, valid, overflow, bcd_tens, bcd_ones};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        steps(3);
        exp = 12'h000; tests++;
        if (obs !== exp) begin fails++; $display("FAIL reset_hold: got %h want %h", obs, exp); end
        rst = 1'b0;
        step();
        exp = 12'h800; tests++;
        if (obs !== exp) begin fails++; $display("FAIL reset_release_start_high: got %h want %h", obs, exp); end
        start = 1'b0;
        do_reset();
    endtask

    task automatic test_normal();
        pulse_start();
        exp = 12'h800; tests++;
        if (obs !== exp) begin fails++; $display("FAIL normal_start: got %h want %h", obs, exp); end
        steps(149);
        pulse_stop();
        exp = 12'h637; tests++;
        if (obs !== exp) begin fails++; $display("FAIL normal_stop_d150: got %h want %h", obs, exp); end
        step();
        exp = 12'h237; tests++;
        if (obs !== exp) begin fails++; $display("FAIL normal_done_falls: got %h want %h", obs, exp); end
    endtask

    task automatic test_boundary();
        pulse_start();
        exp = 12'h800; tests++;
        if (obs !== exp) begin fails++; $display("FAIL boundary_restart_clears: got %h want %h", obs, exp); end
        steps(39);
        exp = 12'h809; tests++;
        if (obs !== exp) begin fails++; $display("FAIL boundary_d39: got %h want %h", obs, exp); end
        pulse_stop();
        exp = 12'h610; tests++;
        if (obs !== exp) begin fails++; $display("FAIL boundary_tick_and_stop_d40: got %h want %h", obs, exp); end
        pulse_start();
        steps(2);
        pulse_stop();
        exp = 12'h600; tests++;
        if (obs !== exp) begin fails++; $display("FAIL boundary_d3: got %h want %h", obs, exp); end
    endtask

    task automatic test_overflow();
        pulse_start();
        steps(399);
        exp = 12'h899; tests++;
        if (obs !== exp) begin fails++; $display("FAIL overflow_d399: got %h want %h", obs, exp); end
        step();
        exp = 12'h799; tests++;
        if (obs !== exp) begin fails++; $display("FAIL overflow_d400: got %h want %h", obs, exp); end
        step();
        exp = 12'h399; tests++;
        if (obs !== exp) begin fails++; $display("FAIL overflow_done_once: got %h want %h", obs, exp); end
        pulse_stop();
        step();
        exp = 12'h399; tests++;
        if (obs !== exp) begin fails++; $display("FAIL overflow_stop_ignored: got %h want %h", obs, exp); end
        pulse_start();
        exp = 12'h800; tests++;
        if (obs !== exp) begin fails++; $display("FAIL overflow_restart_clears: got %h want %h", obs, exp); end
    endtask

    task automatic test_ignored_events();
        do_reset();
        start = 1'b1;
        steps(20);
        start = 1'b0;
        exp = 12'h804; tests++;
        if (obs !== exp) begin fails++; $display("FAIL held_start_single_edge: got %h want %h", obs, exp); end
        steps(2);
        pulse_start();
        exp = 12'h805; tests++;
        if (obs !== exp) begin fails++; $display("FAIL start_in_run_ignored: got %h want %h", obs, exp); end
        steps(7);
        pulse_stop();
        exp = 12'h607; tests++;
        if (obs !== exp) begin fails++; $display("FAIL stop_d30: got %h want %h", obs, exp); end
        pulse_stop();
        exp = 12'h207; tests++;
        if (obs !== exp) begin fails++; $display("FAIL stop_in_hold_ignored: got %h want %h", obs, exp); end
        do_reset();
        pulse_stop();
        exp = 12'h000; tests++;
        if (obs !== exp) begin fails++; $display("FAIL stop_in_idle_ignored: got %h want %h", obs, exp); end
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        exp = 12'h800; tests++;
        if (obs !== exp) begin fails++; $display("FAIL start_stop_same_cycle: got %h want %h", obs, exp); end
        steps(7);
        pulse_stop();
        exp = 12'h602; tests++;
        if (obs !== exp) begin fails++; $display("FAIL after_same_cycle_d8: got %h want %h", obs, exp); end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        steps(49);
        rst = 1'b1;
        step();
        exp = 12'h000; tests++;
        if (obs !== exp) begin fails++; $display("FAIL reset_mid_run: got %h want %h", obs, exp); end
        rst = 1'b0;
        pulse_start();
        steps(11);
        pulse_stop();
        exp = 12'h603; tests++;
        if (obs !== exp) begin fails++; $display("FAIL after_reset_d12: got %h want %h", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_boundary();
        test_overflow();
        test_ignored_events();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
